instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // Instruction addresses are word aligned, so the low two bits are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word addresses to a synchronous instruction
// memory and presents the returned word to decode with a valid/ready handshake.
// A stall re-reads the presented word rather than buffering it, and a redirect
// squashes whatever is currently presented.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetchPc_q, fetchPc_d;
  logic [31:0]  respPc_q, respPc_d;
  logic [31:0]  fetchCount_q, fetchCount_d;
  logic [31:0]  redirectTarget;
  logic         handshake;

  assign redirectTarget = alignPc(redirect_pc);
  assign handshake      = (state_q == RUN) && if_ready;

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fetchPc_q    <= RESET_PC;
      respPc_q     <= RESET_PC;
      fetchCount_q <= '0;
    end else begin
      state_q      <= state_d;
      fetchPc_q    <= fetchPc_d;
      respPc_q     <= respPc_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  // Next-state logic; a redirect overrides stall, halt and acceptance.
  always_comb begin
    state_d      = state_q;
    fetchPc_d    = fetchPc_q;
    respPc_d     = respPc_q;
    fetchCount_d = fetchCount_q;

    if (redirect_valid) begin
      if (!halt) begin
        respPc_d  = redirectTarget;
        fetchPc_d = redirectTarget + PC_INCR;
        state_d   = RUN;
      end else begin
        fetchPc_d = redirectTarget;
        state_d   = IDLE;
      end
    end else begin
      if (handshake) begin
        fetchCount_d = fetchCount_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          if (!halt) begin
            respPc_d  = fetchPc_q;
            fetchPc_d = fetchPc_q + PC_INCR;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (if_ready) begin
            if (!halt) begin
              respPc_d  = fetchPc_q;
              fetchPc_d = fetchPc_q + PC_INCR;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: memory address selection and the decode-facing view.
  always_comb begin
    if_valid    = (state_q == RUN);
    if_pc       = respPc_q;
    if_instr    = imem_rdata;
    fetch_count = fetchCount_q;
    if (redirect_valid) begin
      imem_addr = redirectTarget;
    end else if ((state_q == RUN) && !if_ready) begin
      imem_addr = respPc_q;
    end else begin
      imem_addr = fetchPc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, all compared against a behavioural instruction-stream model.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clock;
  logic        resetN;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        ifValid;
  logic        ifReady;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        halt;
  logic [31:0] fetchCount;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: is an instruction on display, which one, where the
  // sequential stream continues, and how many instructions decode has taken.
  bit          mValid;
  logic [31:0] mPc;
  logic [31:0] mNext;
  logic [31:0] mCount;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset_n        (resetN),
    .imem_addr      (imemAddr),
    .imem_rdata     (imemRdata),
    .if_valid       (ifValid),
    .if_ready       (ifReady),
    .if_instr       (ifInstr),
    .if_pc          (ifPc),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .halt           (halt),
    .fetch_count    (fetchCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clock) imemRdata <= memWord(imemAddr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compare outputs for the current inputs, advance the model, then clock.
  task automatic applyStimulus(input bit rstN, input bit rv, input logic [31:0] rpc,
                               input bit hlt, input bit rdy);
    logic [31:0] target;
    logic [31:0] expAddr;
    resetN        = rstN;
    redirectValid = rv;
    redirectPc    = rpc;
    halt          = hlt;
    ifReady       = rdy;
    #1;
    target  = rpc & ~32'h3;
    expAddr = rv ? target : ((mValid && !rdy) ? mPc : mNext);
    checkOutput("if_valid", {31'b0, ifValid}, {31'b0, mValid});
    checkOutput("fetch_count", fetchCount, mCount);
    checkOutput("imem_addr", imemAddr, expAddr);
    if (mValid) begin
      checkOutput("if_pc", ifPc, mPc);
      checkOutput("if_instr", ifInstr, memWord(mPc));
    end
    if (!rstN) begin
      mValid = 0;
      mPc    = RESET_PC;
      mNext  = RESET_PC;
      mCount = 0;
    end else if (rv) begin
      if (!hlt) begin
        mValid = 1;
        mPc    = target;
        mNext  = target + 32'd4;
      end else begin
        mValid = 0;
        mNext  = target;
      end
    end else if (!mValid) begin
      if (!hlt) begin
        mValid = 1;
        mPc    = mNext;
        mNext  = mNext + 32'd4;
      end
    end else if (rdy) begin
      mCount = mCount + 32'd1;
      if (!hlt) begin
        mPc   = mNext;
        mNext = mNext + 32'd4;
      end else begin
        mValid = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetN        = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    halt          = 1'b0;
    ifReady       = 1'b0;
    mValid        = 0;
    mPc           = RESET_PC;
    mNext         = RESET_PC;
    mCount        = 0;

    // Bring the design out of an unknown power-up state.
    @(posedge clock);
    #1;
    applyStimulus(0, 0, 32'h0, 0, 1);

    // First cycle after reset release is a bubble fetching RESET_PC.
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("first_valid", {31'b0, ifValid}, 32'd1);
    checkOutput("first_pc", ifPc, 32'h0000_3000);
    applyStimulus(1, 0, 32'h0, 0, 1);
    applyStimulus(1, 0, 32'h0, 0, 1);
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("count_after_three", fetchCount, 32'd3);
    checkOutput("pc_after_three", ifPc, 32'h0000_300C);

    // Stall on 300C for three cycles: word re-read, nothing skipped.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h0, 0, 0);
      checkOutput("stall_pc", ifPc, 32'h0000_300C);
    end

    // Halt on acceptance of 300C, then release: one bubble before 3010.
    applyStimulus(1, 0, 32'h0, 1, 1);
    checkOutput("halted_valid", {31'b0, ifValid}, 32'd0);
    applyStimulus(1, 0, 32'h0, 1, 1);
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("resume_pc", ifPc, 32'h0000_3010);

    // Redirect while stalled on 3010: squashed, target aligned, zero bubble.
    applyStimulus(1, 1, 32'h0000_3101, 0, 0);
    checkOutput("redirect_pc", ifPc, 32'h0000_3100);
    checkOutput("redirect_count", fetchCount, 32'd4);
    applyStimulus(1, 0, 32'h0, 0, 1);

    // Redirect while halting parks the stream at the target.
    applyStimulus(1, 1, 32'h0000_4002, 1, 1);
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("parked_pc", ifPc, 32'h0000_4000);

    // Mid-stream reset discards the presented instruction and restarts.
    applyStimulus(0, 0, 32'h0, 0, 1);
    checkOutput("reset_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("reset_count", fetchCount, 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("restart_pc", ifPc, 32'h0000_3000);

    // Address wrap at the top of memory.
    applyStimulus(1, 1, 32'hFFFF_FFFC, 0, 1);
    checkOutput("wrap_top", ifPc, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 32'h0, 0, 1);
    checkOutput("wrap_zero", ifPc, 32'h0000_0000);

    // Randomized traffic mixing stalls, halts, redirects and resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(63) != 0),
                    ($urandom_range(7) == 0),
                    $urandom(),
                    ($urandom_range(5) == 0),
                    ($urandom_range(3) != 0));
    end
    applyStimulus(1, 0, 32'h0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
